// File: rtl/duty_ramp.sv
// rtl/duty_ramp.sv - soft-start / slew-rate limiter feeding the PWM duty input
//
// Steps the registered duty toward an accepted target by STEP once every
// RAMP_DIV PWM periods. The internal period counter matches the PWM counter,
// so every duty change becomes visible on the first cycle of a PWM period.
//
// Ports:
//   clk           in   single clock
//   rst_n         in   asynchronous active-low reset
//   target        in   requested duty (8 bits)
//   target_valid  in   target is presented
//   target_ready  out  a target can be accepted (idle)
//   enable        in   low freezes an in-progress ramp
//   duty          out  registered duty to the PWM (8 bits)
//   busy          out  a ramp is in progress
//   period_start  out  one-cycle pulse on the first cycle of each PWM period
//   done          out  one-cycle pulse when duty reaches the accepted target
module duty_ramp #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int PWM_FREQ = 20_000,
  parameter int RAMP_DIV = 4,
  parameter int STEP     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] target,
  input  logic       target_valid,
  output logic       target_ready,
  input  logic       enable,
  output logic [7:0] duty,
  output logic       busy,
  output logic       period_start,
  output logic       done
);

  localparam int COUNTER_MAX = CLK_FREQ / PWM_FREQ;
  localparam int CW = $clog2(COUNTER_MAX);
  // A one-period divider still needs a 1-bit register to keep widths legal.
  localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNTER_MAX - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(RAMP_DIV - 1);
  localparam logic [8:0]    STEP9    = 9'(STEP);
  localparam logic [7:0]    STEP8    = 8'(STEP);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   div, div_next;
  logic [7:0]      tgt_q, tgt_next;
  logic [7:0]      duty_next;
  logic            done_next;
  logic            tick;
  logic [8:0]      diff;
  logic [8:0]      mag;

  assign tick = (cnt == CNT_LAST);

  // 9-bit two's-complement difference; bit 8 set means the target is below duty.
  assign diff = {1'b0, tgt_q} - {1'b0, duty};
  assign mag  = diff[8] ? (~diff + 9'd1) : diff;

  assign target_ready = (state == IDLE);
  assign busy         = (state == RAMP);

  // Free-running PWM period counter, independent of enable and state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      cnt          <= tick ? '0 : cnt + CW'(1);
      period_start <= tick;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      div   <= '0;
      tgt_q <= 8'd0;
      duty  <= 8'd0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      div   <= div_next;
      tgt_q <= tgt_next;
      duty  <= duty_next;
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    div_next   = div;
    tgt_next   = tgt_q;
    duty_next  = duty;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (target_valid) begin
          tgt_next = target;
          div_next = '0;
          if (target == duty) begin
            done_next = 1'b1;
          end else begin
            state_next = RAMP;
          end
        end
      end
      RAMP: begin
        if (enable && tick) begin
          if (div == DIV_LAST) begin
            div_next = '0;
            // Within one step of the target: land exactly, never overshoot or wrap.
            if (mag <= STEP9) begin
              duty_next  = tgt_q;
              state_next = IDLE;
              done_next  = 1'b1;
            end else if (diff[8]) begin
              duty_next = duty - STEP8;
            end else begin
              duty_next = duty + STEP8;
            end
          end else begin
            div_next = div + DW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_duty_ramp.sv
// tb/tb_duty_ramp.sv - self-checking bench for duty_ramp against a queue-based path model
module tb_duty_ramp;

  localparam int CLK_FREQ = 100;
  localparam int PWM_FREQ = 10;
  localparam int RAMP_DIV = 2;
  localparam int STEP     = 16;
  localparam int CM       = CLK_FREQ / PWM_FREQ;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] target;
  logic       target_valid;
  logic       target_ready;
  logic       enable;
  logic [7:0] duty;
  logic       busy;
  logic       period_start;
  logic       done;

  int checks   = 0;
  int failures = 0;

  // Reference model: the full sequence of duty values for a ramp is planned
  // at accept time; each RAMP_DIV-th enabled period boundary pops the next one.
  int m_duty, m_tgt, m_ticks, m_edges;
  bit m_busy, m_done, m_ps;
  int path[$];

  duty_ramp #(
    .CLK_FREQ(CLK_FREQ),
    .PWM_FREQ(PWM_FREQ),
    .RAMP_DIV(RAMP_DIV),
    .STEP(STEP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .target(target),
    .target_valid(target_valid),
    .target_ready(target_ready),
    .enable(enable),
    .duty(duty),
    .busy(busy),
    .period_start(period_start),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_duty = 0; m_tgt = 0; m_ticks = 0; m_edges = 0;
    m_busy = 0; m_done = 0; m_ps = 0;
    path.delete();
  endtask

  task automatic plan_path(input int from, input int to);
    int d;
    d = from;
    path.delete();
    while (d != to) begin
      if (to > d) d = (to - d <= STEP) ? to : d + STEP;
      else        d = (d - to <= STEP) ? to : d - STEP;
      path.push_back(d);
    end
  endtask

  task automatic model_edge();
    bit tk;
    bit nd;
    tk = ((m_edges % CM) == CM - 1);
    nd = 0;
    if (!m_busy) begin
      if (target_valid) begin
        m_tgt = int'(target);
        if (m_tgt == m_duty) begin
          nd = 1;
        end else begin
          plan_path(m_duty, m_tgt);
          m_busy  = 1;
          m_ticks = 0;
        end
      end
    end else if (enable && tk) begin
      m_ticks++;
      if (m_ticks == RAMP_DIV) begin
        m_ticks = 0;
        m_duty  = path.pop_front();
        if (path.size() == 0) begin
          m_busy = 0;
          nd     = 1;
        end
      end
    end
    m_done = nd;
    m_ps   = tk;
    m_edges++;
  endtask

  task automatic check_outputs();
    check("duty", 32'(duty), 32'(m_duty));
    check("busy", 32'(busy), 32'(m_busy));
    check("target_ready", 32'(target_ready), 32'(!m_busy));
    check("done", 32'(done), 32'(m_done));
    check("period_start", 32'(period_start), 32'(m_ps));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_duty"}, 32'(duty), 32'd0);
    check({tag, "_ready"}, 32'(target_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_period_start"}, 32'(period_start), 32'd0);
  endtask

  // Inputs change at the falling edge; the model sees the same values the DUT
  // captures on the rising edge, and outputs are compared at the next fall.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while (m_busy && k < limit) begin
      cycle();
      k++;
    end
    if (m_busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic send(input int t);
    target       = 8'(t);
    target_valid = 1'b1;
    cycle();
    target_valid = 1'b0;
  endtask

  // Assert reset between edges and confirm outputs clear before the next edge.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values(tag);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    rst_n        = 1'b0;
    target       = 8'd0;
    target_valid = 1'b0;
    enable       = 1'b1;
    model_reset();
    #3 check_reset_values("reset");
    @(negedge clk);
    check_reset_values("reset_hold");
    rst_n = 1'b1;

    run(25);

    send(64);
    wait_idle(200);
    run(3);
    send(10);
    wait_idle(200);
    send(240);
    wait_idle(600);
    send(255);
    wait_idle(200);
    check("no_wrap_255", 32'(duty), 32'd255);

    send(255);
    check("equal_done", 32'(done), 32'd1);
    check("equal_busy", 32'(busy), 32'd0);
    run(3);

    send(0);
    target       = 8'd200;
    target_valid = 1'b1;
    k = 0;
    while (!(m_busy && m_tgt == 200) && k < 800) begin
      cycle();
      k++;
    end
    if (!(m_busy && m_tgt == 200)) check("hold_timeout", 32'd1, 32'd0);
    target_valid = 1'b0;
    wait_idle(400);

    send(120);
    run(15);
    enable = 1'b0;
    run(30);
    enable = 1'b1;
    wait_idle(400);

    send(0);
    wait_idle(400);
    send(64);
    k = 0;
    while (m_duty != 32 && k < 200) begin
      cycle();
      k++;
    end
    if (m_duty != 32) check("reach32_timeout", 32'd1, 32'd0);
    async_reset("midramp");
    run(22);

    for (int i = 0; i < 1500; i++) begin
      target_valid = ($urandom_range(0, 3) == 0);
      target       = ($urandom_range(0, 4) == 0) ? 8'(m_duty) : 8'($urandom_range(0, 255));
      enable       = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 499) == 0) async_reset("rand_reset");
      else cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
